ram_loader: RTL

Byte-stream boot loader placed directly upstream of the 32 KB embedded RAM write port. It parses framed load packets from a host byte source (UART receiver or debug bridge) and writes the payload into RAM at an auto-incrementing address. While a frame is in progress it holds the 6502 core off the bus, so monitor programs can be loaded without resynthesis.

---
 rtl/ram_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: framed byte-stream boot loader for the embedded RAM write port.
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CSUM.
// Every payload byte is written at an auto-incrementing, wrapping address.
// The CPU is held off the bus while a frame is in progress.
// The address split assumes 9 <= ADDR_W <= 16.
module ram_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter int         ADDR_W    = 15,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM
  } state_t;

  // Last idle count before the frame is abandoned.
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);

  state_t              state, state_nx;
  logic                rdy;
  logic [ADDR_W-1:0]   addr;      // next payload write address
  logic                addr_bad;  // ADDR_H had bits set above the RAM size
  logic [15:0]         cnt;       // payload bytes still to come
  logic [7:0]          sum;       // running sum of bytes after SYNC
  logic [7:0]          sum_nx;
  logic [19:0]         tcnt;      // cycles since the last accepted byte
  logic                acc, wr, fin_ok, fin_bad, tmo;

  assign in_ready = rdy;
  assign acc      = in_valid & rdy;
  assign busy     = (state != S_IDLE);
  assign cpu_hold = busy;
  assign sum_nx   = sum + in_data;

  // Ready comes up on the first clock after reset and then stays up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy <= 1'b0;
    else          rdy <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state decode plus the write / completion / timeout strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nx = state;
    wr       = 1'b0;
    fin_ok   = 1'b0;
    fin_bad  = 1'b0;
    tmo      = (state != S_IDLE) && !acc && (tcnt == TO_LAST);
    if (acc) begin
      case (state)
        S_IDLE:   if (in_data == SYNC_BYTE) state_nx = S_ADDR_H;
        S_ADDR_H: state_nx = S_ADDR_L;
        S_ADDR_L: state_nx = S_LEN_H;
        S_LEN_H:  state_nx = S_LEN_L;
        S_LEN_L:  state_nx = ({cnt[15:8], in_data} == 16'd0) ? S_CSUM : S_DATA;
        S_DATA: begin
          wr = !addr_bad;
          if (cnt == 16'd1) state_nx = S_CSUM;
        end
        S_CSUM: begin
          state_nx = S_IDLE;
          if (sum_nx == 8'h00 && !addr_bad) fin_ok  = 1'b1;
          else                              fin_bad = 1'b1;
        end
        default:  state_nx = S_IDLE;
      endcase
    end
    if (tmo) begin
      state_nx = S_IDLE;
      fin_bad  = 1'b1;
    end
  end

  // Frame datapath: header capture, checksum, address/count, RAM port, pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      addr_bad <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      tcnt     <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ram_we <= wr;
      done   <= fin_ok;
      err    <= fin_bad;
      if (wr) begin
        ram_addr <= addr;
        ram_din  <= in_data;
      end
      // The idle timer only runs inside a frame and restarts on every byte.
      if (state == S_IDLE || acc) tcnt <= '0;
      else                        tcnt <= tcnt + 20'd1;
      if (acc) begin
        sum <= (state == S_IDLE) ? 8'h00 : sum_nx;
        case (state)
          S_ADDR_H: begin
            addr[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
            addr_bad         <= (in_data >> (ADDR_W - 8)) != 8'd0;
          end
          S_ADDR_L: addr[7:0]  <= in_data;
          S_LEN_H:  cnt[15:8]  <= in_data;
          S_LEN_L:  cnt[7:0]   <= in_data;
          S_DATA: begin
            cnt  <= cnt - 16'd1;
            addr <= addr + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
